vga_line_reader: RTL and testbench



---
 rtl/vga_line_reader.sv | 128 ++++++++++++
 tb/tb_vga_line_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_line_reader.sv
// VGA scan-out timing and line-RAM read master; the 2-cycle RAM latency is absorbed by a sync/de delay line.
// Optional build macro VGA_PIXEL_DOUBLE_EN: each RAM word and each source line is shown twice.
module vga_line_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  read_clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  line_req,
    output logic [9:0]            line_num,
    output logic                  line_bank,
    output logic                  frame_start,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic [DATA_WIDTH-1:0] vga_pixel
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = ADDR_WIDTH - 1;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_next;
    logic [31:0]   h_pos;
    logic [31:0]   v_pos;
    logic [31:0]   n_pos;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic          req_fire;
    logic [9:0]    req_num;
    logic          req_bank;
    logic [XW-1:0] x_addr;
    logic          rd_bank;
    logic [1:0]    de_d;
    logic [1:0]    hs_d;
    logic [1:0]    vs_d;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        h_pos  = 32'(h_cnt);
        v_pos  = 32'(v_cnt);
        v_next = (v_pos == V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
        n_pos  = 32'(v_next);

        active = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
        hs_on  = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
        vs_on  = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_PIXEL_DOUBLE_EN
        // Source line is v_cnt>>1, so only even display lines need a fresh fill.
        x_addr   = XW'(h_cnt >> 1);
        rd_bank  = v_cnt[1];
        req_fire = (h_pos == H_ACTIVE) && (n_pos < V_ACTIVE) && !v_next[0];
        req_num  = 10'(v_next >> 1);
        req_bank = v_next[1];
`else
        x_addr   = XW'(h_cnt);
        rd_bank  = v_cnt[0];
        req_fire = (h_pos == H_ACTIVE) && (n_pos < V_ACTIVE);
        req_num  = 10'(v_next);
        req_bank = v_next[0];
`endif

        read_address = active ? {rd_bank, x_addr} : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            de_d        <= '0;
            hs_d        <= '0;
            vs_d        <= '0;
            vga_de      <= 1'b0;
            vga_hs      <= ~SYNC_ON;
            vga_vs      <= ~SYNC_ON;
            vga_pixel   <= '0;
            line_req    <= 1'b0;
            line_num    <= '0;
            line_bank   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (h_pos == H_TOTAL - 1) begin
                h_cnt <= '0;
                v_cnt <= v_next;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // Two stages line the controls up with q, the third registers the outputs.
            de_d <= {de_d[0], active};
            hs_d <= {hs_d[0], hs_on};
            vs_d <= {vs_d[0], vs_on};

            vga_de    <= de_d[1];
            vga_hs    <= hs_d[1] ? SYNC_ON : ~SYNC_ON;
            vga_vs    <= vs_d[1] ? SYNC_ON : ~SYNC_ON;
            vga_pixel <= de_d[1] ? q : '0;

            line_req <= req_fire;
            if (req_fire) begin
                line_num  <= req_num;
                line_bank <= req_bank;
            end

            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_line_reader.sv
// Directed bench for vga_line_reader: small timing with a 2-cycle RAM model, plus a default-size instance.
module tb_vga_line_reader;

`ifdef VGA_PIXEL_DOUBLE_EN
    localparam bit DBL  = 1'b1;
    localparam int NREQ = 2;
    int e_c [NREQ] = '{23, 93};
    int e_n [NREQ] = '{1, 0};
    int e_b [NREQ] = '{1, 0};
`else
    localparam bit DBL  = 1'b0;
    localparam int NREQ = 4;
    int e_c [NREQ] = '{9, 23, 37, 93};
    int e_n [NREQ] = '{1, 2, 3, 0};
    int e_b [NREQ] = '{1, 0, 1, 0};
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] read_address;
    logic [7:0]  q;
    logic        line_req, line_bank, frame_start, vga_hs, vga_vs, vga_de;
    logic [9:0]  line_num;
    logic [7:0]  vga_pixel;

    logic [10:0] f_addr;
    logic [7:0]  f_q = 8'h00;
    logic        f_req, f_bank, f_fs, f_hs, f_vs, f_de;
    logic [9:0]  f_num;
    logic [7:0]  f_pix;

    vga_line_reader #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .ADDR_WIDTH(11), .DATA_WIDTH(8)
    ) dut (
        .read_clk(clk), .rst(rst), .read_address(read_address), .q(q),
        .line_req(line_req), .line_num(line_num), .line_bank(line_bank),
        .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_de(vga_de), .vga_pixel(vga_pixel)
    );

    vga_line_reader dut_full (
        .read_clk(clk), .rst(rst), .read_address(f_addr), .q(f_q),
        .line_req(f_req), .line_num(f_num), .line_bank(f_bank),
        .frame_start(f_fs), .vga_hs(f_hs), .vga_vs(f_vs),
        .vga_de(f_de), .vga_pixel(f_pix)
    );

    // Line RAM read port: address registered, then data registered (2-cycle latency).
    logic [7:0]  mem [0:2047];
    logic [10:0] a1 = '0;
    always @(posedge clk) begin
        a1 <= read_address;
        q  <= mem[a1];
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string t);
        check({t, "_de"},    32'(vga_de), 0);
        check({t, "_hs"},    32'(vga_hs), 1);
        check({t, "_vs"},    32'(vga_vs), 1);
        check({t, "_pixel"}, 32'(vga_pixel), 0);
        check({t, "_req"},   32'(line_req), 0);
        check({t, "_num"},   32'(line_num), 0);
        check({t, "_bank"},  32'(line_bank), 0);
        check({t, "_fs"},    32'(frame_start), 0);
    endtask

    function automatic logic [7:0] exp_pix(input int line, input int i);
        int x   = DBL ? i / 2 : i;
        int src = DBL ? line / 2 : line;
        return ((src % 2) != 0 ? 8'h20 : 8'h10) + 8'(x);
    endfunction

    int first_de = -1;
    int de_n = 0, hs_n = 0, vs_n = 0, bad_pix = 0, f_de_n = 0, f_hs_n = 0;
    int pix_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] pix [4][8];
    int rq_c[$], rq_n[$], rq_b[$], fs_c[$];
    int c;

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
        for (int x = 0; x < 8; x++) begin
            mem[x]        = 8'h10 + 8'(x);
            mem[1024 + x] = 8'h20 + 8'(x);
        end

        @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Window 0 is counter state (0,0); sample each window on the falling edge.
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (vga_de && first_de < 0) first_de = k;
            if (k >= 3 && k < 101) begin
                de_n += int'(vga_de);
                hs_n += int'(!vga_hs);
                vs_n += int'(!vga_vs);
            end
            if (vga_de && k < 56) begin
                if (pix_cnt[k / 14] < 8) pix[k / 14][pix_cnt[k / 14]] = vga_pixel;
                pix_cnt[k / 14]++;
            end
            if (!vga_de && vga_pixel !== 8'h00) bad_pix++;
            if (line_req && k < 98) begin
                rq_c.push_back(k);
                rq_n.push_back(int'(line_num));
                rq_b.push_back(int'(line_bank));
            end
            if (frame_start) fs_c.push_back(k);
            f_de_n += int'(f_de);
            f_hs_n += int'(!f_hs);
        end

        check("first_de_clock", first_de, 3);
        check("de_per_frame", de_n, 32);
        check("hs_low_per_frame", hs_n, 14);
        check("vs_low_per_frame", vs_n, 14);
        check("pixel_outside_de", bad_pix, 0);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("de_line%0d", l), pix_cnt[l], 8);
            for (int i = 0; i < 8; i++)
                check($sformatf("pix_l%0d_x%0d", l, i), 32'(pix[l][i]), 32'(exp_pix(l, i)));
        end
        check("line_req_count", rq_c.size(), NREQ);
        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("req%0d_clock", i), rq_c[i], e_c[i]);
            check($sformatf("req%0d_num", i),   rq_n[i], e_n[i]);
            check($sformatf("req%0d_bank", i),  rq_b[i], e_b[i]);
        end
        check("fs_first", fs_c[0], 1);
        check("fs_period", fs_c[1] - fs_c[0], 98);
        check("full_de_line0", f_de_n, 640);
        check("full_hs_low", f_hs_n, 96);

        // Advance to counter state v=2, h=5 and pulse reset for one clock.
        c = 799;
        while (c % 98 != 33) begin
            @(negedge clk);
            c++;
        end
        check("de_before_reset", 32'(vga_de), 1);
        check("num_before_reset", 32'(line_num), DBL ? 1 : 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("mid");
        @(negedge clk);
        check("fs_after_reset", 32'(frame_start), 1);
        check("de_rst_c1", 32'(vga_de), 0);
        @(negedge clk);
        check("de_rst_c2", 32'(vga_de), 0);
        @(negedge clk);
        check("de_rst_c3", 32'(vga_de), 1);
        check("pix_rst_c3", 32'(vga_pixel), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
